// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - core memory-bus connection to the UART transmitter
interface uart_tx_mmio_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;
  logic        sel;

  modport master (output address, write_data, write_enable, input read_data, sel);
  modport slave  (input address, write_data, write_enable, output read_data, sel);
endinterface

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter: TXDATA/STATUS registers, transmit FIFO, serialiser
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic [3:0] offset;
  logic       full, empty, push_req, push, pop, stat_wr, baud_last;
  logic [7:0] head;
  logic       unused_wdata;

  assign offset       = bus.address[3:0];
  assign bus.sel      = bus.address[31:4] == BASE_ADDR[31:4];
  assign full         = count_q == FIFO_FULL;
  assign empty        = count_q == '0;
  assign push_req     = bus.sel && bus.write_enable && offset == 4'h0;
  assign push         = push_req && !full;
  assign stat_wr      = bus.sel && bus.write_enable && offset == 4'h4;
  assign head         = mem_q[rd_ptr_q];
  assign baud_last    = baud_q == BAUD_LAST;
  assign tx           = tx_q;
  assign unused_wdata = ^bus.write_data[31:8];

  always_comb begin
    bus.read_data = '0;
    if (offset == 4'h4)
      bus.read_data = {16'h0, 8'(count_q), 3'b000, PARITY_EN, ovf_q,
                       state_q != IDLE, empty, full};
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = ^head;
          state_d  = START;
        end
      end
      START: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (baud_last)
          state_d = STOP;
      end
      STOP: begin
        // Back-to-back frames: pop straight into the next start bit.
        if (baud_last) begin
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = ^head;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase

    if (state_d != state_q || state_q == IDLE || baud_last)
      baud_d = '0;
    else
      baud_d = baud_q + BW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // A dropped push outranks a same-edge STATUS write.
    if (push_req && full)
      ovf_d = 1'b1;
    else if (stat_wr)
      ovf_d = 1'b0;
    else
      ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.write_data[7:0];
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS   = 11;
  localparam logic [31:0] PAR_BIT = 32'h10;
`else
  localparam int          NBITS   = 10;
  localparam logic [31:0] PAR_BIT = 32'h0;
`endif
  localparam int          F         = NBITS * CPB;
  localparam logic [31:0] BASE      = 32'h0001_0000;
  localparam logic [31:0] STAT      = BASE + 32'h4;
  localparam logic [31:0] STAT_IDLE = 32'h2 | PAR_BIT;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_sel;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  int   n_tests = 0;
  int   n_fail = 0;
  logic       txlog[$];
  logic [7:0] exp_bytes[$];
  vec_t       vecs[$];

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    bus.write_enable = 1'b0;
    bus.address      = STAT;
    #1;
    check(name, bus.read_data, exp);
  endtask

  task automatic store(input logic [7:0] b);
    bus.address      = BASE;
    bus.write_data   = {24'hABCDEF, b};
    bus.write_enable = 1'b1;
    tick();
    bus.write_enable = 1'b0;
    bus.address      = STAT;
    #1;
  endtask

  function automatic logic exp_bit(input int k);
    int f = k / F;
    int r = (k % F) / CPB;
    if (f >= exp_bytes.size()) return 1'b1;
    if (r == 0) return 1'b0;
    if (r <= 8) return exp_bytes[f][r-1];
    if (NBITS == 11 && r == 9) return ^exp_bytes[f];
    return 1'b1;
  endfunction

  // Compares the captured line from its first start bit against the expected frames.
  task automatic check_log(input string name);
    int s = -1;
    int bad = 0;
    foreach (txlog[i]) if (s < 0 && txlog[i] == 1'b0) s = i;
    n_tests++;
    if (s < 0) begin
      n_fail++;
      $display("FAIL %s: no start bit seen, expected %0d frames", name, exp_bytes.size());
      return;
    end
    if (txlog.size() < s + exp_bytes.size() * F) bad++;
    for (int i = 0; i < s; i++) if (txlog[i] !== 1'b1) bad++;
    for (int i = s; i < txlog.size(); i++) if (txlog[i] !== exp_bit(i - s)) bad++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad line samples, expected 0", name, bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        txlog.push_back(tx);
      end
    join_none

    bus.address = '0; bus.write_data = '0; bus.write_enable = 1'b0;
    #2 reset = 1'b1;
    #1 check("reset_tx", {31'b0, tx}, 32'h1);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    vecs.push_back('{"rd_status",    STAT,              32'h0,  1'b0, 1'b1, 1'b1, STAT_IDLE});
    vecs.push_back('{"rd_txdata",    BASE,              32'h0,  1'b0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"rd_res8",      BASE + 32'h8,      32'h0,  1'b0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"rd_resC",      BASE + 32'hC,      32'h0,  1'b0, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"sel_other",    32'h0002_0004,     32'h0,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"sel_above",    32'h0001_0014,     32'h0,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"sel_below",    32'h0000_0004,     32'h0,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"wr_res8",      BASE + 32'h8,      32'hFF, 1'b1, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"stat_after8",  STAT,              32'h0,  1'b0, 1'b1, 1'b1, STAT_IDLE});
    vecs.push_back('{"wr_status",    STAT,              32'h0,  1'b1, 1'b1, 1'b1, STAT_IDLE});
    vecs.push_back('{"wr_resC",      BASE + 32'hC,      32'h55, 1'b1, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{"stat_afterC",  STAT,              32'h0,  1'b0, 1'b1, 1'b1, STAT_IDLE});
    vecs.push_back('{"wr_unsel",     32'h0002_0000,     32'h77, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"stat_unsel",   STAT,              32'h0,  1'b0, 1'b1, 1'b1, STAT_IDLE});

    foreach (vecs[i]) begin
      bus.address      = vecs[i].addr;
      bus.write_data   = vecs[i].wdata;
      bus.write_enable = vecs[i].we;
      #1;
      check({vecs[i].name, "_sel"}, {31'b0, bus.sel}, {31'b0, vecs[i].exp_sel});
      if (vecs[i].chk_rd) check({vecs[i].name, "_rd"}, bus.read_data, vecs[i].exp_rd);
      tick();
      bus.write_enable = 1'b0;
    end
    check("idle_tx", {31'b0, tx}, 32'h1);

    // Single frame: latency, busy window, exact waveform.
    txlog.delete();
    exp_bytes = '{8'hA5};
    store(8'hA5);
    check("a5_count1", bus.read_data, 32'h0000_0100 | PAR_BIT);
    check("a5_tx_pre", {31'b0, tx}, 32'h1);
    tick();
    check("a5_tx_start", {31'b0, tx}, 32'h0);
    read_status("a5_busy_start", 32'h6 | PAR_BIT);
    repeat (F - 1) tick();
    read_status("a5_busy_last", 32'h6 | PAR_BIT);
    tick();
    read_status("a5_idle", STAT_IDLE);
    repeat (4) tick();
    check_log("a5_wave");

    // Contiguous frames with FIFO count tracking.
    txlog.delete();
    exp_bytes = '{8'h11, 8'h07, 8'h33, 8'h44};
    store(8'h11);
    tick();
    for (int j = 1; j < 4; j++) begin
      store(exp_bytes[j]);
      check($sformatf("b2b_count%0d", j), bus.read_data, (32'(j) << 8) | 32'h4 | PAR_BIT);
    end
    repeat (F - 3) tick();
    read_status("b2b_dec2", 32'h0204 | PAR_BIT);
    repeat (F) tick();
    read_status("b2b_dec1", 32'h0104 | PAR_BIT);
    repeat (F) tick();
    read_status("b2b_dec0", 32'h0006 | PAR_BIT);
    repeat (F) tick();
    read_status("b2b_idle", STAT_IDLE);
    repeat (4) tick();
    check_log("b2b_wave");

    // Overflow: ten stores into an 8-deep FIFO while the first frame runs.
    txlog.delete();
    exp_bytes.delete();
    for (int i = 0; i < 10; i++) begin
      store(8'h30 + 8'(i));
      if (i < 9) exp_bytes.push_back(8'h30 + 8'(i));
      if (i == 8) check("ovf_full", bus.read_data, 32'h0805 | PAR_BIT);
    end
    check("ovf_set", bus.read_data, 32'h080D | PAR_BIT);
    bus.address = STAT; bus.write_data = 32'h0; bus.write_enable = 1'b1;
    tick();
    read_status("ovf_clear", 32'h0805 | PAR_BIT);
    repeat (9 * F) tick();
    read_status("ovf_idle", STAT_IDLE);
    repeat (8) tick();
    check_log("ovf_wave");

    // Reset in the middle of a data bit.
    store(8'h5A);
    repeat (7) tick();
    check("rst_tx_bit0", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    check("rst_tx_async", {31'b0, tx}, 32'h1);
    repeat (2) tick();
    reset = 1'b0;
    read_status("rst_status", STAT_IDLE);
    tick();
    txlog.delete();
    exp_bytes = '{8'hC3};
    store(8'hC3);
    repeat (F + 4) tick();
    read_status("rst_idle", STAT_IDLE);
    check_log("rst_wave");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
